// File: rtl/nios2_debug_cmd_router.sv
// ----------------------------------------------------------------------------
// nios2_debug_cmd_router
//
// Clock-domain command router for a shared Nios II debug slave that serves
// NUM_CORES cores. JTAG update-DR events arrive as a level toggle that is
// asynchronous to clk. Each event is captured together with the JTAG IR/SR.
// Ordinary commands are queued in a small FIFO. They are then dispatched one
// at a time to a selectable subset of cores, using a valid/ready handshake
// for each core. A reserved IR code (SEL_IR) never reaches the FIFO. It
// reprograms the destination mask instead, and can clear the sticky flags.
//
// Optional feature (macro DBG_ROUTER_TIMEOUT_EN):
//   When this macro is defined, an 11-bit timer bounds how long a command may
//   wait in ISSUE. Cores that have not accepted by then are recorded in
//   tmo_sticky, and the command is retired. Without the macro, ISSUE waits
//   indefinitely and tmo_sticky reads as zero.
//
// Ports:
//   clk           in   1                     system clock
//   reset_n       in   1                     async active-low reset
//   jtag_udr_tgl  in   1                     toggles once per update-DR (async)
//   ir_in         in   IR_W                  JTAG IR, stable around each toggle
//   sr            in   SR_W                  JTAG SR, stable around each toggle
//   jdo           out  SR_W                  data of the command being issued
//   cmd_ir        out  IR_W                  IR of the command being issued
//   cmd_valid     out  NUM_CORES             per-core command valid
//   cmd_ready     in   NUM_CORES             per-core accept
//   core_mask     out  NUM_CORES             current destination mask
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
//   ovf_sticky    out  1                     a command was dropped (FIFO full)
//   tmo_sticky    out  NUM_CORES             a core missed the accept deadline
// ----------------------------------------------------------------------------
module nios2_debug_cmd_router #(
    parameter int              NUM_CORES  = 4,
    parameter int              SR_W       = 38,
    parameter int              IR_W       = 3,
    parameter logic [IR_W-1:0] SEL_IR     = 3'b111,
    parameter int              FIFO_DEPTH = 4,
    parameter int              TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          jtag_udr_tgl,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    output logic [SR_W-1:0]               jdo,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [NUM_CORES-1:0]          cmd_valid,
    input  logic [NUM_CORES-1:0]          cmd_ready,
    output logic [NUM_CORES-1:0]          core_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_sticky,
    output logic [NUM_CORES-1:0]          tmo_sticky
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENTRY_W = NUM_CORES + IR_W + SR_W;

    // Parameter sanity checks, evaluated once at elaboration.
    if (NUM_CORES < 1 || NUM_CORES > SR_W - 1) begin : g_bad_num_cores
        $error("NUM_CORES must be in 1..SR_W-1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 0 || TIMEOUT >= 2048) begin : g_bad_timeout
        $error("TIMEOUT must fit in the 11-bit timer");
    end

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   pending_q, pending_d, pending_left;
    logic                   load, pop;

    logic                   tgl_ff1, tgl_ff2, tgl_ff3;
    logic                   upd, is_sel, push_req, clear_sticky;
    logic                   fifo_full, do_push, ovf_evt;

    logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0]     head;
    logic [NUM_CORES-1:0]   head_mask;
    logic [IR_W-1:0]        head_ir;
    logic [SR_W-1:0]        head_sr;

    // The toggle input goes through a two-flop synchroniser. A third flop
    // then holds the previous synchronised level. Comparing the last two
    // flops gives exactly one clk pulse for each toggle, in either direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgl_ff1 <= 1'b0;
            tgl_ff2 <= 1'b0;
            tgl_ff3 <= 1'b0;
        end else begin
            tgl_ff1 <= jtag_udr_tgl;
            tgl_ff2 <= tgl_ff1;
            tgl_ff3 <= tgl_ff2;
        end
    end

    // Decode the event. A push that meets a full FIFO is still taken if the
    // dispatcher retires the head in the same cycle, because that frees the
    // slot being written. A zero destination mask silently discards the
    // command.
    assign upd          = tgl_ff2 ^ tgl_ff3;
    assign is_sel       = upd && (ir_in == SEL_IR);
    assign push_req     = upd && (ir_in != SEL_IR) && (core_mask != '0);
    assign clear_sticky = is_sel && sr[SR_W-1];
    assign fifo_full    = (fifo_level == LW'(FIFO_DEPTH));
    assign do_push      = push_req && (!fifo_full || pop);
    assign ovf_evt      = push_req && fifo_full && !pop;

    assign head      = fifo_mem[rd_ptr];
    assign head_mask = head[ENTRY_W-1 -: NUM_CORES];
    assign head_ir   = head[SR_W +: IR_W];
    assign head_sr   = head[SR_W-1:0];

    // The core-select command updates the destination mask. Commands that
    // are already queued keep the mask they were captured with.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_mask <= NUM_CORES'(1);
        end else if (is_sel) begin
            core_mask <= sr[NUM_CORES-1:0];
        end
    end

    // FIFO storage has no reset. An entry is only read after it has been
    // written, and fifo_level is what tells the dispatcher whether a valid
    // entry exists.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= {core_mask, ir_in, sr};
        end
    end

    // FIFO pointers and occupancy. Because the depth is a power of two, the
    // pointers wrap naturally. A simultaneous push and pop leaves the level
    // unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // The overflow flag stays set until a core-select command with the top
    // SR bit set clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (clear_sticky) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_evt) begin
            ovf_sticky <= 1'b1;
        end
    end

    // Cores that handshake this cycle drop out of the pending set right away.
    // This means the command can retire in the same cycle as its last accept.
    assign pending_left = pending_q & ~cmd_ready;

`ifdef DBG_ROUTER_TIMEOUT_EN
    localparam logic [10:0] TMO_VAL = 11'(TIMEOUT);

    logic [10:0]          timer_q;
    logic [NUM_CORES-1:0] tmo_set;
    logic [NUM_CORES-1:0] tmo_q;

    // The timer restarts from zero on every entry to ISSUE. It advances once
    // for each cycle spent there. ISSUE always exits at TIMEOUT at the
    // latest, so the timer can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (load) begin
            timer_q <= '0;
        end else if (state_q == ISSUE) begin
            timer_q <= timer_q + 11'd1;
        end
    end

    // Each core that was still pending when the deadline expired is recorded.
    // The flags accumulate until a core-select command clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (clear_sticky) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q | tmo_set;
        end
    end

    assign tmo_sticky = tmo_q;
`else
    assign tmo_sticky = '0;
`endif

    // Dispatch FSM: next-state logic and control strobes. On leaving IDLE,
    // the FSM snapshots the head entry's mask into pending. The head is
    // popped only after every destination core has accepted, or (when the
    // timeout option is built in) after the deadline expires.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        load      = 1'b0;
        pop       = 1'b0;
`ifdef DBG_ROUTER_TIMEOUT_EN
        tmo_set   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_d   = ISSUE;
                    pending_d = head_mask;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                pending_d = pending_left;
                if (pending_left == '0) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
`ifdef DBG_ROUTER_TIMEOUT_EN
                else if (timer_q == TMO_VAL) begin
                    tmo_set   = pending_left;
                    pending_d = '0;
                    pop       = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // FSM state and pending-set registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // The command payload is latched on entry to ISSUE. This keeps jdo and
    // cmd_ir stable for the whole handshake, even while new entries are being
    // pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo    <= '0;
            cmd_ir <= '0;
        end else if (load) begin
            jdo    <= head_sr;
            cmd_ir <= head_ir;
        end
    end

    assign cmd_valid = (state_q == ISSUE) ? pending_q : '0;

endmodule

// File: tb/tb_nios2_debug_cmd_router.sv
// ----------------------------------------------------------------------------
// tb_nios2_debug_cmd_router
//
// Self-checking bench for nios2_debug_cmd_router (4 cores, 38-bit SR, 3-bit
// IR, 4-deep FIFO, TIMEOUT=15). The bench queues each command it expects to
// be forwarded when it drives the toggle. A monitor pops that queue whenever
// cmd_valid rises from all-zero, and compares the issued mask, IR and data.
// The directed sequences check latency, per-core handshakes, overflow,
// timeout (or indefinite wait when DBG_ROUTER_TIMEOUT_EN is undefined),
// the zero-mask discard, and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_nios2_debug_cmd_router;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jtag_udr_tgl = 1'b0;
    logic [2:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic [3:0]  cmd_ready = '0;
    logic [37:0] jdo;
    logic [2:0]  cmd_ir;
    logic [3:0]  cmd_valid;
    logic [3:0]  core_mask;
    logic [2:0]  fifo_level;
    logic        ovf_sticky;
    logic [3:0]  tmo_sticky;

    typedef struct packed {
        logic [3:0]  mask;
        logic [2:0]  ir;
        logic [37:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] mask_m = 4'b0001;
    int         vectors = 0;
    int         miscompares = 0;

    nios2_debug_cmd_router #(
        .NUM_CORES  (4),
        .SR_W       (38),
        .IR_W       (3),
        .SEL_IR     (3'b111),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .jtag_udr_tgl (jtag_udr_tgl),
        .ir_in        (ir_in),
        .sr           (sr),
        .jdo          (jdo),
        .cmd_ir       (cmd_ir),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .core_mask    (core_mask),
        .fifo_level   (fifo_level),
        .ovf_sticky   (ovf_sticky),
        .tmo_sticky   (tmo_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present IR/SR six cycles ahead of the toggle, then flip the toggle and
    // return. The caller decides whether the DUT should forward the command.
    task automatic applyStimulus(input logic [2:0] ir, input logic [37:0] data, input bit accept);
        @(negedge clk);
        ir_in = ir;
        sr    = data;
        repeat (6) @(negedge clk);
        if (ir == 3'b111) begin
            mask_m = data[3:0];
        end else if (accept) begin
            exp_q.push_back('{mask: mask_m, ir: ir, data: data});
        end
        jtag_udr_tgl = ~jtag_udr_tgl;
    endtask

    task automatic settle();
        repeat (7) @(negedge clk);
    endtask

    task automatic waitIssue(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 64'(seen), 64'd1);
    endtask

    // Scoreboard monitor: a rising cmd_valid marks a new command issue.
    initial begin
        logic [3:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (prev == '0 && cmd_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_issue", 64'(cmd_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("issue_mask", 64'(cmd_valid), 64'(e.mask));
                    checkOutput("issue_ir", 64'(cmd_ir), 64'(e.ir));
                    checkOutput("issue_jdo", 64'(jdo), 64'(e.data));
                end
            end
            prev = cmd_valid;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         edge_idx;
        logic [3:0] ready_acc;
        logic [3:0] exp_v;
        int         c1, c2;
        bit         seen;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_jdo", 64'(jdo), 64'd0);
        checkOutput("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        checkOutput("rst_valid", 64'(cmd_valid), 64'd0);
        checkOutput("rst_mask", 64'(core_mask), 64'd1);
        checkOutput("rst_level", 64'(fifo_level), 64'd0);
        checkOutput("rst_ovf", 64'(ovf_sticky), 64'd0);
        checkOutput("rst_tmo", 64'(tmo_sticky), 64'd0);

        // ---------------- 1: single command, latency, handshake ----------------
        applyStimulus(3'd1, 38'h15, 1'b1);
        edge_idx = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (cmd_valid != '0) begin
                edge_idx = e;
                break;
            end
        end
        // The first edge after the toggle is the one at which ff1 captures it.
        checkOutput("t1_latency_edge", 64'(edge_idx), 64'd4);
        checkOutput("t1_valid", 64'(cmd_valid), 64'b0001);
        checkOutput("t1_level_busy", 64'(fifo_level), 64'd1);
        @(negedge clk);
        cmd_ready = 4'b0001;
        @(posedge clk);
        #1;
        checkOutput("t1_valid_drop", 64'(cmd_valid), 64'd0);
        checkOutput("t1_level_pop", 64'(fifo_level), 64'd0);
        @(negedge clk);
        cmd_ready = '0;

        // ---------------- 2: multi-core, staggered ready ----------------
        applyStimulus(3'b111, 38'b1011, 1'b0);
        settle();
        checkOutput("t2_mask", 64'(core_mask), 64'b1011);
        checkOutput("t2_sel_no_push", 64'(fifo_level), 64'd0);
        applyStimulus(3'd2, 38'h2A_5A5A_0F0F, 1'b1);
        waitIssue("t2_issue_seen");
        ready_acc = '0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t == 0) ready_acc = ready_acc | 4'b0001;
            if (t == 3) ready_acc = ready_acc | 4'b0010;
            if (t == 7) ready_acc = ready_acc | 4'b1000;
            cmd_ready = ready_acc;
            @(posedge clk);
            #1;
            exp_v = 4'b1011 & ~ready_acc;
            checkOutput("t2_valid_bits", 64'(cmd_valid), 64'(exp_v));
            checkOutput("t2_level", 64'(fifo_level), (exp_v != '0) ? 64'd1 : 64'd0);
            if (t < 7) begin
                checkOutput("t2_jdo_stable", 64'(jdo), 64'h2A_5A5A_0F0F);
            end
        end
        @(negedge clk);
        cmd_ready = '0;

        // ---------------- 3: overflow, sticky clear, ordered drain ----------------
        applyStimulus(3'b111, 38'h1, 1'b0);
        settle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'(k), 38'h100 + 38'(k), (k < 4));
            settle();
            if (k == 3) begin
                checkOutput("t3_level_full", 64'(fifo_level), 64'd4);
                checkOutput("t3_ovf_before", 64'(ovf_sticky), 64'd0);
            end
            if (k == 4) begin
                checkOutput("t3_ovf_set", 64'(ovf_sticky), 64'd1);
            end
        end
        checkOutput("t3_level_sat", 64'(fifo_level), 64'd4);
        applyStimulus(3'b111, 38'h20_0000_0001, 1'b0);
        settle();
        checkOutput("t3_ovf_cleared", 64'(ovf_sticky), 64'd0);
        checkOutput("t3_mask", 64'(core_mask), 64'b0001);
        @(negedge clk);
        cmd_ready = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (fifo_level == '0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t3_drained", 64'(seen), 64'd1);
        checkOutput("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        cmd_ready = '0;

        // ---------------- 4: timeout / indefinite wait ----------------
        applyStimulus(3'b111, 38'b0110, 1'b0);
        settle();
        @(negedge clk);
        cmd_ready = 4'b0010;
        applyStimulus(3'd3, 38'h3C3C, 1'b1);
`ifdef DBG_ROUTER_TIMEOUT_EN
        c1 = 0;
        c2 = 0;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid[1]) c1++;
            if (cmd_valid[2]) begin
                c2++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        checkOutput("t4_core1_cycles", 64'(c1), 64'd1);
        checkOutput("t4_core2_cycles", 64'(c2), 64'(TMO + 1));
        checkOutput("t4_tmo", 64'(tmo_sticky), 64'b0100);
        checkOutput("t4_level", 64'(fifo_level), 64'd0);
        applyStimulus(3'd4, 38'h77, 1'b1);
        waitIssue("t4_next_issue");
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (cmd_valid == '0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t4_next_retired", 64'(seen), 64'd1);
`else
        c1 = 0;
        c2 = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cmd_valid[1]) c1++;
            if (cmd_valid[2]) c2++;
        end
        checkOutput("t4_core1_cycles", 64'(c1), 64'd1);
        checkOutput("t4_wait_valid", 64'(cmd_valid), 64'b0100);
        checkOutput("t4_tmo_zero", 64'(tmo_sticky), 64'd0);
        checkOutput("t4_level", 64'(fifo_level), 64'd1);
        @(negedge clk);
        cmd_ready = 4'b0110;
        @(posedge clk);
        #1;
        checkOutput("t4_late_accept", 64'(cmd_valid), 64'd0);
        checkOutput("t4_level_pop", 64'(fifo_level), 64'd0);
`endif
        @(negedge clk);
        cmd_ready = '0;
        applyStimulus(3'b111, 38'h20_0000_0001, 1'b0);
        settle();
        checkOutput("t4_tmo_cleared", 64'(tmo_sticky), 64'd0);

        // ---------------- 5: zero mask discard, async reset ----------------
        applyStimulus(3'b111, 38'h0, 1'b0);
        settle();
        checkOutput("t5_mask_zero", 64'(core_mask), 64'd0);
        applyStimulus(3'd5, 38'h55, 1'b0);
        settle();
        checkOutput("t5_no_push", 64'(fifo_level), 64'd0);
        checkOutput("t5_no_valid", 64'(cmd_valid), 64'd0);
        checkOutput("t5_no_ovf", 64'(ovf_sticky), 64'd0);
        applyStimulus(3'b111, 38'h1, 1'b0);
        settle();
        applyStimulus(3'd6, 38'h1234, 1'b1);
        settle();
        applyStimulus(3'd2, 38'h5678, 1'b1);
        settle();
        checkOutput("t5_busy_valid", 64'(cmd_valid), 64'b0001);
        checkOutput("t5_busy_level", 64'(fifo_level), 64'd2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_jdo", 64'(jdo), 64'd0);
        checkOutput("t5_rst_cmd_ir", 64'(cmd_ir), 64'd0);
        checkOutput("t5_rst_valid", 64'(cmd_valid), 64'd0);
        checkOutput("t5_rst_mask", 64'(core_mask), 64'd1);
        checkOutput("t5_rst_level", 64'(fifo_level), 64'd0);
        checkOutput("t5_rst_ovf", 64'(ovf_sticky), 64'd0);
        checkOutput("t5_rst_tmo", 64'(tmo_sticky), 64'd0);
        exp_q.delete();
        mask_m = 4'b0001;
        jtag_udr_tgl = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t5_queue_lost", 64'(fifo_level), 64'd0);
        checkOutput("t5_idle_after", 64'(cmd_valid), 64'd0);

        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
